// File: rtl/tx_word_ser_if.sv
// Parallel-word input handshake for tx_word_ser: the producer drives din/din_valid,
// the serializer answers with din_ready.
interface tx_word_ser_if #(
  parameter int unsigned W = 32
) ();
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/tx_word_ser.sv
// Transmit word serializer: small input FIFO feeding an LSB-first bit stream,
// with one '1' sync bit at the start of every burst so the receiver can align words.
module tx_word_ser #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          IDLE_BIT   = 1'b0,
  localparam int unsigned W    = 2 ** STAGES,
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rstb_i,
  input  logic            en_i,
  tx_word_ser_if.slave    in_if,
  output logic            dout_o,
  output logic            word_start_o,
  output logic            busy_o,
  output logic            underflow_o,
  output logic [LvlW-1:0] fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] cnt_q, cnt_d;
  logic [W-1:0]      shreg_q, shreg_d;
  logic              dout_q, dout_d;
  logic              ws_q, ws_d;
  logic              uf_q, uf_d;

  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              din_ready;
  logic              push, pop, fifo_nonempty;
  logic [W-1:0]      head;

  assign din_ready       = level_q < LvlW'(FIFO_DEPTH);
  assign in_if.din_ready = din_ready;
  assign push            = in_if.din_valid && din_ready;
  assign fifo_nonempty   = level_q != '0;
  assign head            = mem_q[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_if.din;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = IDLE_BIT;
    ws_d    = 1'b0;
    uf_d    = uf_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i && fifo_nonempty) begin
          dout_d  = 1'b1;
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        dout_d = shreg_q[cnt_q];
        ws_d   = (cnt_q == '0);
        cnt_d  = cnt_q + STAGES'(1);
        // Word boundary: chain the next word, pad with a filler, or stop.
        if (cnt_q == STAGES'(W - 1)) begin
          if (en_i && fifo_nonempty) begin
            pop     = 1'b1;
            shreg_d = head;
          end else if (en_i) begin
            shreg_d = {W{IDLE_BIT}};
            uf_d    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= IDLE_BIT;
      ws_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      ws_q    <= ws_d;
      uf_q    <= uf_d;
    end
  end

  assign dout_o       = dout_q;
  assign word_start_o = ws_q;
  assign busy_o       = (state_q == StData);
  assign underflow_o  = uf_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_tx_word_ser.sv
// Bench for tx_word_ser: random words pushed through a queue model whose expected
// serial stream (sync bit + LSB-first words) is compared bit by bit against dout.
module tb_tx_word_ser;
  localparam int unsigned W       = 32;
  localparam bit          IdleBit = 1'b0;

  logic       clk_i = 1'b0;
  logic       rstb_i;
  logic       en_i;
  logic       dout_o, word_start_o, busy_o, underflow_o;
  logic [2:0] fifo_level_o;

  tx_word_ser_if #(.W(W)) bus ();

  tx_word_ser #(
    .STAGES    (5),
    .FIFO_DEPTH(4),
    .IDLE_BIT  (IdleBit)
  ) dut (
    .clk_i       (clk_i),
    .rstb_i      (rstb_i),
    .en_i        (en_i),
    .in_if       (bus.slave),
    .dout_o      (dout_o),
    .word_start_o(word_start_o),
    .busy_o      (busy_o),
    .underflow_o (underflow_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_q[$];
  logic        exp_bits[$];
  logic        exp_ws[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstb_i        = 1'b0;
    en_i          = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    model_q.delete();
    tick();
    tick();
    rstb_i = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    model_q.push_back(w);
  endtask

  // Expected line stream for one burst: a sync bit, then every queued word LSB first.
  function automatic void build_expected();
    exp_bits.delete();
    exp_ws.delete();
    exp_bits.push_back(1'b1);
    exp_ws.push_back(1'b0);
    foreach (model_q[j]) begin
      for (int i = 0; i < W; i++) begin
        exp_bits.push_back(model_q[j][i]);
        exp_ws.push_back(i == 0);
      end
    end
  endfunction

  task automatic test_reset();
    rstb_i        = 1'b0;
    en_i          = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    checks++;
    if ({dout_o, word_start_o, busy_o, underflow_o} !== {IdleBit, 3'b000}) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {dout_o, word_start_o, busy_o, underflow_o},
               {IdleBit, 3'b000});
    end
    checks++;
    if (fifo_level_o !== 3'd0 || bus.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo got level=%0d ready=%b exp level=0 ready=1", fifo_level_o,
               bus.din_ready);
    end
    rstb_i = 1'b1;
    tick();
    tick();
    checks++;
    if (dout_o !== IdleBit || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got dout=%b busy=%b exp dout=%b busy=0", dout_o, busy_o,
               IdleBit);
    end
  endtask

  task automatic test_known_word_underflow();
    do_reset();
    en_i = 1'b1;
    push_word(32'hA5A5_0F0F);
    build_expected();
    for (int k = 0; k < exp_bits.size(); k++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {exp_bits[k], exp_ws[k]}) begin
        failures++;
        $display("FAIL known_bit%0d got dout/ws=%b%b exp=%b%b", k, dout_o, word_start_o,
                 exp_bits[k], exp_ws[k]);
      end
      if (k == 0) begin
        checks++;
        if (busy_o !== 1'b1) begin
          failures++;
          $display("FAIL known_busy got=%b exp=1", busy_o);
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if (underflow_o !== (k == 32)) begin
          failures++;
          $display("FAIL underflow_at_bit%0d got=%b exp=%b", k, underflow_o, k == 32);
        end
      end
    end
    // Filler word: aligned, word_start on its bit 0; en drops mid-filler.
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {IdleBit, i == 0}) begin
        failures++;
        $display("FAIL filler_bit%0d got dout/ws=%b%b exp=%b%b", i, dout_o, word_start_o,
                 IdleBit, i == 0);
      end
      if (i == 10) en_i = 1'b0;
    end
    tick();
    checks++;
    if ({dout_o, busy_o, underflow_o} !== {IdleBit, 2'b01}) begin
      failures++;
      $display("FAIL after_filler got dout/busy/uf=%b exp=%b", {dout_o, busy_o, underflow_o},
               {IdleBit, 2'b01});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int j = 0; j < 3; j++) push_word($urandom);
    tick();
    checks++;
    if (fifo_level_o !== 3'd3 || busy_o !== 1'b0 || dout_o !== IdleBit) begin
      failures++;
      $display("FAIL b2b_prefill got level=%0d busy=%b dout=%b exp 3 0 %b", fifo_level_o,
               busy_o, dout_o, IdleBit);
    end
    en_i = 1'b1;
    build_expected();
    for (int k = 0; k < exp_bits.size(); k++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {exp_bits[k], exp_ws[k]}) begin
        failures++;
        $display("FAIL b2b_bit%0d got dout/ws=%b%b exp=%b%b", k, dout_o, word_start_o,
                 exp_bits[k], exp_ws[k]);
      end
      if (k == exp_bits.size() - 20) en_i = 1'b0;
    end
    tick();
    checks++;
    if ({dout_o, busy_o, underflow_o, fifo_level_o} !== {IdleBit, 2'b00, 3'd0}) begin
      failures++;
      $display("FAIL b2b_end got dout/busy/uf/level=%b exp=%b",
               {dout_o, busy_o, underflow_o, fifo_level_o}, {IdleBit, 2'b00, 3'd0});
    end
  endtask

  task automatic test_fifo_full();
    logic exp_ready;
    do_reset();
    bus.din_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.din   = $urandom;
      exp_ready = model_q.size() < 4;
      checks++;
      if (bus.din_ready !== exp_ready) begin
        failures++;
        $display("FAIL full_ready%0d got=%b exp=%b", c, bus.din_ready, exp_ready);
      end
      tick();
      if (exp_ready) model_q.push_back(bus.din);
      checks++;
      if (fifo_level_o !== 3'(model_q.size())) begin
        failures++;
        $display("FAIL full_level%0d got=%0d exp=%0d", c, fifo_level_o, model_q.size());
      end
    end
    bus.din_valid = 1'b0;
    en_i          = 1'b1;
    build_expected();
    for (int k = 0; k < exp_bits.size(); k++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {exp_bits[k], exp_ws[k]}) begin
        failures++;
        $display("FAIL full_bit%0d got dout/ws=%b%b exp=%b%b", k, dout_o, word_start_o,
                 exp_bits[k], exp_ws[k]);
      end
      if (k == exp_bits.size() - 20) en_i = 1'b0;
    end
    tick();
    checks++;
    if ({dout_o, busy_o, underflow_o} !== {IdleBit, 2'b00}) begin
      failures++;
      $display("FAIL full_end got dout/busy/uf=%b exp=%b", {dout_o, busy_o, underflow_o},
               {IdleBit, 2'b00});
    end
  endtask

  task automatic test_en_drop_mid_word();
    logic [31:0] w0, w1;
    do_reset();
    w0 = $urandom;
    w1 = $urandom;
    push_word(w0);
    push_word(w1);
    en_i = 1'b1;
    tick();
    checks++;
    if ({dout_o, word_start_o} !== 2'b10) begin
      failures++;
      $display("FAIL drop_sync0 got dout/ws=%b%b exp=10", dout_o, word_start_o);
    end
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {w0[i], i == 0}) begin
        failures++;
        $display("FAIL drop_w0_bit%0d got dout/ws=%b%b exp=%b%b", i, dout_o, word_start_o,
                 w0[i], i == 0);
      end
      if (i == 9) en_i = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({dout_o, busy_o, fifo_level_o} !== {IdleBit, 1'b0, 3'd1}) begin
        failures++;
        $display("FAIL drop_idle%0d got dout/busy/level=%b exp=%b", i,
                 {dout_o, busy_o, fifo_level_o}, {IdleBit, 1'b0, 3'd1});
      end
    end
    en_i = 1'b1;
    tick();
    checks++;
    if ({dout_o, word_start_o} !== 2'b10) begin
      failures++;
      $display("FAIL drop_sync1 got dout/ws=%b%b exp=10", dout_o, word_start_o);
    end
    for (int i = 0; i < W; i++) begin
      tick();
      checks++;
      if ({dout_o, word_start_o} !== {w1[i], i == 0}) begin
        failures++;
        $display("FAIL drop_w1_bit%0d got dout/ws=%b%b exp=%b%b", i, dout_o, word_start_o,
                 w1[i], i == 0);
      end
      if (i == 15) en_i = 1'b0;
    end
    tick();
    checks++;
    if ({dout_o, busy_o, underflow_o} !== {IdleBit, 2'b00}) begin
      failures++;
      $display("FAIL drop_end got dout/busy/uf=%b exp=%b", {dout_o, busy_o, underflow_o},
               {IdleBit, 2'b00});
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    push_word($urandom | 32'h0000_0020);
    push_word($urandom);
    push_word($urandom);
    en_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    // Now dout carries bit 5 of the first word, which is forced to 1.
    checks++;
    if ({dout_o, busy_o, fifo_level_o} !== {2'b11, 3'd2}) begin
      failures++;
      $display("FAIL rstmid_pre got dout/busy/level=%b exp=%b", {dout_o, busy_o, fifo_level_o},
               {2'b11, 3'd2});
    end
    #2 rstb_i = 1'b0;
    #1;
    checks++;
    if ({dout_o, word_start_o, busy_o, fifo_level_o} !== {IdleBit, 2'b00, 3'd0}) begin
      failures++;
      $display("FAIL rstmid_async got dout/ws/busy/level=%b exp=%b",
               {dout_o, word_start_o, busy_o, fifo_level_o}, {IdleBit, 2'b00, 3'd0});
    end
    #2 rstb_i = 1'b1;
    model_q.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({dout_o, busy_o} !== {IdleBit, 1'b0}) begin
        failures++;
        $display("FAIL rstmid_noresume%0d got dout/busy=%b%b exp=%b0", i, dout_o, busy_o,
                 IdleBit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_word_underflow();
    test_back_to_back();
    test_fifo_full();
    test_en_drop_mid_word();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
